net_packet_rx: RTL and testbench

NET_PACKET_RX -- requirements
Module: net_packet_rx

---
 rtl/net_packet_rx_pkg.sv | 31 +++
 rtl/net_rx_fifo.sv | 61 ++++++
 rtl/net_packet_rx.sv | 164 ++++++++++++++++
 tb/tb_net_packet_rx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_packet_rx_pkg.sv
// Shared types for the network packet receiver: packet layout, opcodes,
// receiver FSM states and the widths of the register-file and barrier paths.
package net_packet_rx_pkg;

    localparam int mask_length_gp = 8;   // barrier mask width
    localparam int rs_imm_size_gp = 5;   // register-file address width

    // Opcode 0 is the NULL (idle) packet; a cleared input register reads as NULL.
    typedef enum logic [2:0] {
        OP_NULL  = 3'd0,
        OP_INSTR = 3'd1,
        OP_REG   = 3'd2,
        OP_PC    = 3'd3,
        OP_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [9:0]  id;
        net_op_e     net_op;
        logic [2:0]  reserved;
        logic [31:0] net_data;
        logic [15:0] net_addr;
    } net_packet_s;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/net_rx_fifo.sv
// Buffer for register-file writes. Handshake: a transfer happens on a side in
// every cycle where both valid and ready are high on that side. in_ready also
// accepts a write into a full buffer when the head is popped in the same cycle.
// There is no bypass: a write into an empty buffer becomes visible next cycle.
module net_rx_fifo #(
    parameter int WIDTH_P = 37,
    parameter int DEPTH_P = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WIDTH_P-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH_P-1:0] out_data,
    input  logic               out_ready,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH_P);
    localparam int CW = AW + 1;

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;

    assign full      = (count == CW'(DEPTH_P));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/net_packet_rx.sv
// Network packet receiver for one core. Registers the incoming packet, then
// decodes the registered copy: INSTR writes instruction memory, REG writes are
// buffered for the register file, BAR loads the barrier mask and PC starts a
// drain-then-load sequence that releases the core from halt.
// Optional: define NET_RX_STATS_EN to add packet and drop counters.
module net_packet_rx
    import net_packet_rx_pkg::*;
#(
    parameter logic [9:0] CORE_ID_P     = 10'd1,
    parameter int         FIFO_DEPTH_P  = 4,
    parameter int         IMEM_ADDR_W_P = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  net_packet_s               net_packet_i,
    output logic                      imem_wen_o,
    output logic [IMEM_ADDR_W_P-1:0]  imem_addr_o,
    output logic [15:0]               imem_data_o,
    output logic                      rf_wen_o,
    output logic [rs_imm_size_gp-1:0] rf_addr_o,
    output logic [31:0]               rf_data_o,
    input  logic                      rf_ready_i,
    output logic [mask_length_gp-1:0] bar_mask_o,
    output logic                      pc_wen_o,
    output logic [IMEM_ADDR_W_P-1:0]  pc_o,
    output logic                      run_o,
    output logic                      drop_o,
    output logic [1:0]                state_o
`ifdef NET_RX_STATS_EN
    ,
    output logic [31:0]               pkt_count_o,
    output logic [15:0]               drop_count_o
`endif
);

    localparam logic [1:0] ST_HALT  = HALT;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam int         FW       = rs_imm_size_gp + 32;

    net_packet_s              pkt_r;
    logic                     hit;
    logic                     is_instr;
    logic                     is_reg;
    logic                     is_bar;
    logic                     is_pc;
    logic [FW-1:0]            fifo_in;
    logic [FW-1:0]            fifo_out;
    logic                     fifo_in_ready;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [1:0]               state;
    logic [1:0]               state_n;
    logic                     load_pc;
    logic [IMEM_ADDR_W_P-1:0] pend_pc;
    logic                     run_r;
    logic                     unused_bits;

    // Single input register; everything downstream decodes this copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pkt_r <= '0;
        else       pkt_r <= net_packet_i;
    end

    assign hit      = (pkt_r.id == CORE_ID_P) && (pkt_r.net_op != OP_NULL);
    assign is_instr = hit && (pkt_r.net_op == OP_INSTR);
    assign is_reg   = hit && (pkt_r.net_op == OP_REG);
    assign is_bar   = hit && (pkt_r.net_op == OP_BAR);
    assign is_pc    = hit && (pkt_r.net_op == OP_PC);

    assign fifo_in  = {pkt_r.net_addr[rs_imm_size_gp-1:0], pkt_r.net_data};

    net_rx_fifo #(
        .WIDTH_P (FW),
        .DEPTH_P (FIFO_DEPTH_P)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (is_reg),
        .in_data   (fifo_in),
        .in_ready  (fifo_in_ready),
        .out_valid (rf_wen_o),
        .out_data  (fifo_out),
        .out_ready (rf_ready_i),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rf_addr_o = fifo_out[FW-1:32];
    assign rf_data_o = fifo_out[31:0];

    // Next-state logic: a PC packet always (re)enters DRAIN; DRAIN completes
    // only once the buffer is empty and no REG write arrives that cycle.
    always_comb begin
        state_n = state;
        load_pc = 1'b0;
        case (state)
            ST_HALT:  if (is_pc) state_n = ST_DRAIN;
            ST_DRAIN: if (!is_pc && fifo_empty && !is_reg) begin
                state_n = ST_RUN;
                load_pc = 1'b1;
            end
            ST_RUN:   if (is_pc) state_n = ST_DRAIN;
            default:  state_n = ST_HALT;
        endcase
    end

    // FSM state, pending PC and the run flag, which stays set through a
    // re-drain once the core has been released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_HALT;
            pend_pc <= '0;
            run_r   <= 1'b0;
        end else begin
            state <= state_n;
            if (is_pc)   pend_pc <= pkt_r.net_data[IMEM_ADDR_W_P-1:0];
            if (load_pc) run_r   <= 1'b1;
        end
    end

    // Registered strobes and held output values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_wen_o  <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            bar_mask_o  <= '0;
            pc_wen_o    <= 1'b0;
            pc_o        <= '0;
            drop_o      <= 1'b0;
        end else begin
            imem_wen_o <= is_instr;
            if (is_instr) begin
                imem_addr_o <= pkt_r.net_addr[IMEM_ADDR_W_P-1:0];
                imem_data_o <= pkt_r.net_data[15:0];
            end
            if (is_bar) bar_mask_o <= pkt_r.net_data[mask_length_gp-1:0];
            pc_wen_o <= load_pc;
            if (load_pc) pc_o <= pend_pc;
            drop_o <= is_reg && !fifo_in_ready;
        end
    end

    assign run_o   = run_r;
    assign state_o = state;

`ifdef NET_RX_STATS_EN
    // Accepted-packet counter (wraps) and drop counter (saturates).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (hit && !(is_reg && !fifo_in_ready)) pkt_count_o <= pkt_count_o + 32'd1;
            if (is_reg && !fifo_in_ready && drop_count_o != 16'hFFFF)
                drop_count_o <= drop_count_o + 16'd1;
        end
    end
`endif

    assign unused_bits = ^{pkt_r.reserved, pkt_r.net_addr, fifo_full};

endmodule

// File: tb/tb_net_packet_rx.sv
// Bench for net_packet_rx: reset checks, a directed vector table, hand-written
// drain/PC/reset sequences, and random traffic against a queue-based model.
// Timing: inputs are driven at the falling edge, the DUT registers them at the
// next rising edge and acts on them one rising edge later; outputs are
// sampled at the falling edge.
module tb_net_packet_rx;
    import net_packet_rx_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [9:0] CORE_ID = 10'd1;

    logic        clk = 1'b0;
    logic        reset;
    net_packet_s net_packet_i;
    logic        imem_wen_o;
    logic [9:0]  imem_addr_o;
    logic [15:0] imem_data_o;
    logic        rf_wen_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        rf_ready_i;
    logic [7:0]  bar_mask_o;
    logic        pc_wen_o;
    logic [9:0]  pc_o;
    logic        run_o;
    logic        drop_o;
    logic [1:0]  state_o;
`ifdef NET_RX_STATS_EN
    logic [31:0] pkt_count_o;
    logic [15:0] drop_count_o;
`endif

    net_packet_rx dut (
        .clk          (clk),
        .reset        (reset),
        .net_packet_i (net_packet_i),
        .imem_wen_o   (imem_wen_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .rf_wen_o     (rf_wen_o),
        .rf_addr_o    (rf_addr_o),
        .rf_data_o    (rf_data_o),
        .rf_ready_i   (rf_ready_i),
        .bar_mask_o   (bar_mask_o),
        .pc_wen_o     (pc_wen_o),
        .pc_o         (pc_o),
        .run_o        (run_o),
        .drop_o       (drop_o),
        .state_o      (state_o)
`ifdef NET_RX_STATS_EN
        ,
        .pkt_count_o  (pkt_count_o),
        .drop_count_o (drop_count_o)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [36:0] exp_q[$];      // {rf_addr, rf_data} pending register writes
    net_packet_s m_pkt;
    logic        m_imem_wen, m_drop, m_pc_wen, m_run, m_drain;
    logic [9:0]  m_imem_addr, m_pc, m_pend;
    logic [15:0] m_imem_data;
    logic [7:0]  m_bar;
    int          m_pkt_count, m_drop_count;

    task automatic model_reset();
        exp_q.delete();
        m_pkt = '0;
        m_imem_wen = 0; m_drop = 0; m_pc_wen = 0; m_run = 0; m_drain = 0;
        m_imem_addr = 0; m_pc = 0; m_pend = 0; m_imem_data = 0; m_bar = 0;
        m_pkt_count = 0; m_drop_count = 0;
    endtask

    // Effect of the next rising edge, given the packet/ready driven now.
    task automatic model_step(input net_packet_s p, input logic rdy);
        bit hit, pop, was_drain, do_push, blocks;
        int n;
        hit = (m_pkt.id == CORE_ID) && (m_pkt.net_op != OP_NULL);
        n = exp_q.size();
        pop = (n > 0) && rdy;
        was_drain = m_drain;
        do_push = 0;
        m_imem_wen = 0; m_drop = 0; m_pc_wen = 0;
        blocks = hit && (m_pkt.net_op == OP_PC || m_pkt.net_op == OP_REG);
        if (hit) begin
            m_pkt_count++;
            case (m_pkt.net_op)
                OP_INSTR: begin
                    m_imem_wen = 1;
                    m_imem_addr = m_pkt.net_addr[9:0];
                    m_imem_data = m_pkt.net_data[15:0];
                end
                OP_REG: begin
                    if (n < DEPTH || pop) do_push = 1;
                    else begin
                        m_drop = 1;
                        m_pkt_count--;
                        if (m_drop_count < 16'hFFFF) m_drop_count++;
                    end
                end
                OP_BAR: m_bar = m_pkt.net_data[7:0];
                OP_PC: begin
                    m_pend = m_pkt.net_data[9:0];
                    m_drain = 1;
                end
                default: ;
            endcase
        end
        if (was_drain && n == 0 && !blocks) begin
            m_drain = 0; m_run = 1; m_pc_wen = 1; m_pc = m_pend;
        end
        if (pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({m_pkt.net_addr[4:0], m_pkt.net_data});
        m_pkt = p;
    endtask

    task automatic check_all();
        logic [1:0] exp_state;
        exp_state = m_drain ? DRAIN : (m_run ? RUN : HALT);
        check("rf_wen", rf_wen_o, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("rf_addr", rf_addr_o, exp_q[0][36:32]);
            check("rf_data", rf_data_o, exp_q[0][31:0]);
        end
        check("imem_wen", imem_wen_o, m_imem_wen);
        check("imem_addr", imem_addr_o, m_imem_addr);
        check("imem_data", imem_data_o, m_imem_data);
        check("bar_mask", bar_mask_o, m_bar);
        check("drop", drop_o, m_drop);
        check("pc_wen", pc_wen_o, m_pc_wen);
        check("pc", pc_o, m_pc);
        check("run", run_o, m_run);
        check("state", state_o, exp_state);
`ifdef NET_RX_STATS_EN
        check("pkt_count", pkt_count_o, 32'(m_pkt_count));
        check("drop_count", drop_count_o, 16'(m_drop_count));
`endif
    endtask

    // ---------------- driver ----------------
    function automatic net_packet_s mkp(input logic [9:0] id, input net_op_e op,
                                        input logic [31:0] data, input logic [15:0] addr);
        net_packet_s p;
        p = '0;
        p.id = id; p.net_op = op; p.net_data = data; p.net_addr = addr;
        return p;
    endfunction

    task automatic cycle(input net_packet_s p, input logic rdy);
        net_packet_i = p;
        rf_ready_i = rdy;
        model_step(p, rdy);
        @(negedge clk);
        check_all();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        net_packet_s pkt;
        logic        rdy;
        logic        e_rf_wen;
        logic [4:0]  e_rf_addr;
        logic        e_imem_wen;
        logic        e_drop;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input net_packet_s p, input logic rdy, input logic rf_wen,
                       input logic [4:0] rf_addr, input logic imem_wen, input logic drop);
        vec_t v;
        v.pkt = p; v.rdy = rdy; v.e_rf_wen = rf_wen; v.e_rf_addr = rf_addr;
        v.e_imem_wen = imem_wen; v.e_drop = drop;
        vecs.push_back(v);
    endtask

    function automatic net_packet_s reg_pkt(input logic [4:0] a);
        return mkp(CORE_ID, OP_REG, 32'h100 + 32'(a), 16'(a));
    endfunction

    net_packet_s nul;
    int pulses;

    initial begin
        nul = '0;
        // Each row: input driven this cycle, expected outputs one rising edge
        // later (so they reflect the packet of the previous row).
        add(mkp(10'd1, OP_INSTR, 32'h0000A1C3, 16'd5), 0, 0, 0, 0, 0);
        add(nul,                                     0, 0, 0, 1, 0);
        add(mkp(10'd2, OP_INSTR, 32'h00001234, 16'd7), 0, 0, 0, 0, 0);
        add(nul,                                     0, 0, 0, 0, 0);
        add(reg_pkt(0), 0, 0, 0, 0, 0);
        add(reg_pkt(1), 0, 1, 0, 0, 0);
        add(reg_pkt(2), 0, 1, 0, 0, 0);
        add(reg_pkt(3), 0, 1, 0, 0, 0);
        add(reg_pkt(4), 0, 1, 0, 0, 0);
        add(reg_pkt(5), 0, 1, 0, 0, 1);
        add(nul,        0, 1, 0, 0, 1);
        add(nul,        0, 1, 0, 0, 0);
        add(nul,        1, 1, 1, 0, 0);
        add(nul,        1, 1, 2, 0, 0);
        add(nul,        1, 1, 3, 0, 0);
        add(nul,        1, 0, 0, 0, 0);
        add(reg_pkt(8), 0, 0, 0, 0, 0);
        add(reg_pkt(9), 0, 1, 8, 0, 0);
        add(reg_pkt(10), 0, 1, 8, 0, 0);
        add(reg_pkt(11), 0, 1, 8, 0, 0);
        add(reg_pkt(12), 0, 1, 8, 0, 0);
        add(nul,        1, 1, 9, 0, 0);
        add(nul,        0, 1, 9, 0, 0);
        add(nul,        1, 1, 10, 0, 0);
        add(nul,        1, 1, 11, 0, 0);
        add(nul,        1, 1, 12, 0, 0);
        add(nul,        1, 0, 0, 0, 0);
        add(nul,        0, 0, 0, 0, 0);

        // Reset
        reset = 1'b1;
        net_packet_i = '0;
        rf_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_rf_wen", rf_wen_o, 1'b0);
        check("rst_run", run_o, 1'b0);
        check("rst_state", state_o, HALT);
        check("rst_pc", pc_o, 10'd0);
        check("rst_bar", bar_mask_o, 8'd0);
        check("rst_strobes", {imem_wen_o, pc_wen_o, drop_o}, 3'b000);
        reset = 1'b0;
        check_all();

        foreach (vecs[i]) begin
            cycle(vecs[i].pkt, vecs[i].rdy);
            check($sformatf("tbl%0d_rf_wen", i), rf_wen_o, vecs[i].e_rf_wen);
            if (vecs[i].e_rf_wen) begin
                check($sformatf("tbl%0d_rf_addr", i), rf_addr_o, vecs[i].e_rf_addr);
                check($sformatf("tbl%0d_rf_data", i), rf_data_o, 32'h100 + 32'(vecs[i].e_rf_addr));
            end
            check($sformatf("tbl%0d_imem_wen", i), imem_wen_o, vecs[i].e_imem_wen);
            if (vecs[i].e_imem_wen) begin
                check($sformatf("tbl%0d_imem_addr", i), imem_addr_o, 10'd5);
                check($sformatf("tbl%0d_imem_data", i), imem_data_o, 16'hA1C3);
            end
            check($sformatf("tbl%0d_drop", i), drop_o, vecs[i].e_drop);
            check($sformatf("tbl%0d_run", i), run_o, 1'b0);
        end

        // Drain from HALT: two buffered writes, then PC=5
        cycle(reg_pkt(1), 0);
        cycle(reg_pkt(2), 0);
        cycle(mkp(CORE_ID, OP_PC, 32'd5, 16'd0), 0);
        cycle(nul, 0);
        check("drain_state", state_o, DRAIN);
        check("drain_run", run_o, 1'b0);
        cycle(nul, 0);
        cycle(nul, 0);
        check("drain_hold_state", state_o, DRAIN);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(nul, 1);
            if (pc_wen_o) pulses++;
        end
        check("load_pulses", pulses, 1);
        check("load_pc", pc_o, 10'd5);
        check("load_run", run_o, 1'b1);
        check("load_state", state_o, RUN);

        // Re-drain from RUN: run stays high, second PC load
        cycle(reg_pkt(3), 0);
        cycle(mkp(CORE_ID, OP_PC, 32'd9, 16'd0), 0);
        cycle(nul, 0);
        check("redrain_state", state_o, DRAIN);
        check("redrain_run", run_o, 1'b1);
        check("redrain_pc_held", pc_o, 10'd5);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(nul, 1);
            if (pc_wen_o) pulses++;
        end
        check("reload_pulses", pulses, 1);
        check("reload_pc", pc_o, 10'd9);

        // Barrier mask, then asynchronous reset mid-drain
        cycle(mkp(CORE_ID, OP_BAR, 32'h2, 16'd0), 0);
        cycle(nul, 0);
        check("bar_mask", bar_mask_o, 8'h02);
        cycle(reg_pkt(4), 0);
        cycle(mkp(CORE_ID, OP_PC, 32'd3, 16'd0), 0);
        cycle(nul, 0);
        check("pre_rst_state", state_o, DRAIN);
        check("pre_rst_rf_wen", rf_wen_o, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_rf_wen", rf_wen_o, 1'b0);
        check("arst_run", run_o, 1'b0);
        check("arst_bar", bar_mask_o, 8'd0);
        check("arst_state", state_o, HALT);
        check_all();
        net_packet_i = '0;
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            net_packet_s p;
            logic [9:0] id;
            id = ($urandom_range(0, 4) == 0) ? 10'(($urandom_range(2, 5))) : CORE_ID;
            p = mkp(id, net_op_e'(3'($urandom_range(0, 4))), $urandom, 16'($urandom));
            if (p.net_op == OP_PC && $urandom_range(0, 3) != 0) p.net_op = OP_NULL;
            cycle(p, ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) cycle(nul, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
